// File: rtl/execute_stage.sv
// Execute stage: operand forwarding from MEM/WB, ALU, EX/MEM pipeline register.
// Latency: one cycle from ID/EX inputs to the *_M outputs.
// Backpressure: none; the EX/MEM register captures on every rising edge.
module execute_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Extend_E,
    input  logic [2:0]      Alu_op_E,
    input  logic            Alu_src_E,
    input  logic            DM_Write_E,
    input  logic            Result_E,
    input  logic            RF_WE_E,
    input  logic [4:0]      RD_E,
    input  logic [4:0]      Rs1_E,
    input  logic [4:0]      Rs2_E,
    input  logic [XLEN-1:0] Result_W,
    input  logic [4:0]      RD_W,
    input  logic            RF_WE_W,
    output logic [XLEN-1:0] ALU_Result_M,
    output logic [XLEN-1:0] WD_M,
    output logic [4:0]      RD_M,
    output logic            RF_WE_M,
    output logic            DM_Write_M,
    output logic            Result_M,
    output logic            Zero_M
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    logic [XLEN-1:0] alu_result_q, alu_result_d;
    logic [XLEN-1:0] wd_q;
    logic [4:0]      rd_q;
    logic            rf_we_q, dm_write_q, result_q, zero_q;

    logic [XLEN-1:0] src_a, fwd_b, src_b;
    logic            mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
    logic [4:0]      shamt;

    // Hazard match terms; x0 is never forwarded because it always reads zero.
    assign mem_hit_a = rf_we_q && (rd_q != 5'd0) && (rd_q == Rs1_E);
    assign mem_hit_b = rf_we_q && (rd_q != 5'd0) && (rd_q == Rs2_E);
    assign wb_hit_a  = RF_WE_W && (RD_W != 5'd0) && (RD_W == Rs1_E);
    assign wb_hit_b  = RF_WE_W && (RD_W != 5'd0) && (RD_W == Rs2_E);

    // Operand selection: the younger MEM result wins over WB. Loads in MEM are
    // forwarded as-is; the hazard unit is responsible for stalling load-use.
    always_comb begin
        src_a = RD1_E;
        fwd_b = RD2_E;
        if (mem_hit_a)     src_a = alu_result_q;
        else if (wb_hit_a) src_a = Result_W;
        if (mem_hit_b)     fwd_b = alu_result_q;
        else if (wb_hit_b) fwd_b = Result_W;
        src_b = Alu_src_E ? Extend_E : fwd_b;
    end

    assign shamt = src_b[4:0];

    // ALU: all arithmetic wraps modulo 2^XLEN; SLT is a signed compare.
    always_comb begin
        alu_result_d = '0;
        case (alu_op_e'(Alu_op_E))
            ALU_ADD: alu_result_d = src_a + src_b;
            ALU_SUB: alu_result_d = src_a - src_b;
            ALU_AND: alu_result_d = src_a & src_b;
            ALU_OR:  alu_result_d = src_a | src_b;
            ALU_XOR: alu_result_d = src_a ^ src_b;
            ALU_SLT: alu_result_d = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLL: alu_result_d = src_a << shamt;
            ALU_SRL: alu_result_d = src_a >> shamt;
            default: alu_result_d = '0;
        endcase
    end

    // EX/MEM register; reset discards whatever instruction is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_result_q <= '0;
            wd_q         <= '0;
            rd_q         <= '0;
            rf_we_q      <= 1'b0;
            dm_write_q   <= 1'b0;
            result_q     <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            alu_result_q <= alu_result_d;
            wd_q         <= fwd_b;
            rd_q         <= RD_E;
            rf_we_q      <= RF_WE_E;
            dm_write_q   <= DM_Write_E;
            result_q     <= Result_E;
            zero_q       <= (alu_result_d == '0);
        end
    end

    assign ALU_Result_M = alu_result_q;
    assign WD_M         = wd_q;
    assign RD_M         = rd_q;
    assign RF_WE_M      = rf_we_q;
    assign DM_Write_M   = dm_write_q;
    assign Result_M     = result_q;
    assign Zero_M       = zero_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: reset, forwarding priority, x0 guard,
// immediate/store data, ALU operations and asynchronous mid-stream reset.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] RD1_E, RD2_E, Extend_E, Result_W;
    logic [2:0]  Alu_op_E;
    logic        Alu_src_E, DM_Write_E, Result_E, RF_WE_E, RF_WE_W;
    logic [4:0]  RD_E, Rs1_E, Rs2_E, RD_W;
    logic [31:0] ALU_Result_M, WD_M;
    logic [4:0]  RD_M;
    logic        RF_WE_M, DM_Write_M, Result_M, Zero_M;

    int n_checks = 0;
    int n_fails  = 0;

    execute_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Extend_E(Extend_E),
        .Alu_op_E(Alu_op_E), .Alu_src_E(Alu_src_E), .DM_Write_E(DM_Write_E),
        .Result_E(Result_E), .RF_WE_E(RF_WE_E), .RD_E(RD_E),
        .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .Result_W(Result_W), .RD_W(RD_W), .RF_WE_W(RF_WE_W),
        .ALU_Result_M(ALU_Result_M), .WD_M(WD_M), .RD_M(RD_M),
        .RF_WE_M(RF_WE_M), .DM_Write_M(DM_Write_M), .Result_M(Result_M),
        .Zero_M(Zero_M)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Set up one instruction with register sources (Alu_src_E = 0).
    task automatic op(input logic [2:0] aop, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic we);
        Alu_op_E = aop;  RD1_E = a;  RD2_E = b;
        Rs1_E = rs1;     Rs2_E = rs2; RD_E = rd; RF_WE_E = we;
        Alu_src_E = 1'b0; Extend_E = 32'h0; DM_Write_E = 1'b0; Result_E = 1'b0;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] val);
        RF_WE_W = we; RD_W = rd; Result_W = val;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu"},  ALU_Result_M, 32'h0);
        check({tag, "_wd"},   WD_M, 32'h0);
        check({tag, "_rd"},   {27'h0, RD_M}, 32'h0);
        check({tag, "_rfwe"}, {31'h0, RF_WE_M}, 32'h0);
        check({tag, "_dmw"},  {31'h0, DM_Write_M}, 32'h0);
        check({tag, "_res"},  {31'h0, Result_M}, 32'h0);
        check({tag, "_zero"}, {31'h0, Zero_M}, 32'h0);
    endtask

    initial begin
        // Reset held with nonzero inputs across several edges.
        rst = 1'b0;
        op(3'b000, 32'h1234, 32'h5678, 5'd1, 5'd2, 5'd7, 1'b1);
        DM_Write_E = 1'b1; Result_E = 1'b1;
        wb(1'b1, 5'd3, 32'h99);
        repeat (3) tick();
        check_all_zero("reset_hold");

        // Release away from an edge; first capture on the next edge.
        rst = 1'b1;
        wb(1'b0, 5'd0, 32'h0);
        op(3'b000, 32'd5, 32'd7, 5'd1, 5'd2, 5'd1, 1'b0);
        tick();
        check("add_5_7", ALU_Result_M, 32'd12);
        check("add_zero_flag", {31'h0, Zero_M}, 32'h0);
        check("add_rd", {27'h0, RD_M}, 32'd1);

        // MEM forward: x3 = 30, then SUB x3 - 5.
        op(3'b000, 32'd10, 32'd20, 5'd1, 5'd2, 5'd3, 1'b1);
        tick();
        check("mem_prod", ALU_Result_M, 32'd30);
        check("mem_prod_we", {31'h0, RF_WE_M}, 32'd1);
        op(3'b001, 32'hDEAD, 32'd5, 5'd3, 5'd5, 5'd6, 1'b0);
        tick();
        check("mem_fwd_sub", ALU_Result_M, 32'd25);

        // MEM beats WB: x4 = 100 in MEM, x4 = 200 in WB.
        op(3'b000, 32'd60, 32'd40, 5'd1, 5'd2, 5'd4, 1'b1);
        tick();
        check("prio_prod", ALU_Result_M, 32'd100);
        wb(1'b1, 5'd4, 32'd200);
        op(3'b000, 32'd1, 32'd2, 5'd4, 5'd4, 5'd7, 1'b0);
        tick();
        check("prio_mem_wins", ALU_Result_M, 32'd200);
        check("prio_mem_wd", WD_M, 32'd100);

        // Same, but MEM does not write back: WB value used for both operands.
        wb(1'b0, 5'd0, 32'h0);
        op(3'b000, 32'd60, 32'd40, 5'd1, 5'd2, 5'd4, 1'b0);
        tick();
        check("nowe_prod_we", {31'h0, RF_WE_M}, 32'h0);
        wb(1'b1, 5'd4, 32'd200);
        op(3'b000, 32'd1, 32'd2, 5'd4, 5'd4, 5'd7, 1'b0);
        tick();
        check("prio_wb_only", ALU_Result_M, 32'd400);
        check("prio_wb_wd", WD_M, 32'd200);

        // x0 guard: MEM (and WB) target x0 must not be forwarded.
        wb(1'b0, 5'd0, 32'h0);
        op(3'b000, 32'd4, 32'd5, 5'd1, 5'd2, 5'd0, 1'b1);
        tick();
        check("x0_prod", ALU_Result_M, 32'd9);
        wb(1'b1, 5'd0, 32'd77);
        op(3'b000, 32'd0, 32'd3, 5'd0, 5'd2, 5'd9, 1'b0);
        tick();
        check("x0_guard", ALU_Result_M, 32'd3);

        // Immediate operand; store data still follows forwarded rs2.
        wb(1'b1, 5'd8, 32'h55);
        op(3'b000, 32'd4, 32'h11, 5'd1, 5'd8, 5'd10, 1'b0);
        Alu_src_E = 1'b1; Extend_E = 32'hFFFF_FFFC; DM_Write_E = 1'b1; Result_E = 1'b1;
        tick();
        check("imm_add", ALU_Result_M, 32'h0);
        check("imm_zero", {31'h0, Zero_M}, 32'd1);
        check("imm_wd_fwd", WD_M, 32'h55);
        check("imm_dmw", {31'h0, DM_Write_M}, 32'd1);
        check("imm_res", {31'h0, Result_M}, 32'd1);

        // ALU operations.
        wb(1'b0, 5'd0, 32'h0);
        op(3'b101, 32'hFFFF_FFFF, 32'd1, 5'd1, 5'd2, 5'd11, 1'b0);
        tick();
        check("slt_neg", ALU_Result_M, 32'd1);
        op(3'b101, 32'd1, 32'hFFFF_FFFF, 5'd1, 5'd2, 5'd11, 1'b0);
        tick();
        check("slt_pos", ALU_Result_M, 32'd0);
        check("slt_zero_flag", {31'h0, Zero_M}, 32'd1);
        op(3'b110, 32'd1, 32'd31, 5'd1, 5'd2, 5'd11, 1'b0);
        tick();
        check("sll_31", ALU_Result_M, 32'h8000_0000);
        op(3'b111, 32'h8000_0000, 32'd31, 5'd1, 5'd2, 5'd11, 1'b0);
        tick();
        check("srl_31", ALU_Result_M, 32'h1);
        op(3'b001, 32'd0, 32'd1, 5'd1, 5'd2, 5'd11, 1'b0);
        tick();
        check("sub_wrap", ALU_Result_M, 32'hFFFF_FFFF);
        op(3'b010, 32'hF0F0, 32'hFF00, 5'd1, 5'd2, 5'd11, 1'b0);
        tick();
        check("and", ALU_Result_M, 32'hF000);
        op(3'b011, 32'hF0F0, 32'hFF00, 5'd1, 5'd2, 5'd11, 1'b0);
        tick();
        check("or", ALU_Result_M, 32'hFFF0);
        op(3'b100, 32'hF0F0, 32'hFFFF, 5'd1, 5'd2, 5'd12, 1'b1);
        DM_Write_E = 1'b1;
        tick();
        check("xor", ALU_Result_M, 32'h0F0F);

        // Mid-stream reset clears outputs without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        rst = 1'b1;
        op(3'b000, 32'd1, 32'd1, 5'd1, 5'd2, 5'd13, 1'b0);
        tick();
        check("post_rst_add", ALU_Result_M, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (EX) stage of the 5-stage F-D-E-M-WB pipeline.
- Consumes the ID/EX register outputs produced by the decode stage (operands, immediate, control, register addresses).
- Resolves RAW hazards by forwarding from the MEM and WB stages, performs the ALU operation, and registers results into the EX/MEM pipeline register for the memory stage.

Parameters:
- XLEN, 32, datapath width of operands, immediate and results.

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- RD1_E  in  XLEN  rs1 operand from ID/EX register
- RD2_E  in  XLEN  rs2 operand from ID/EX register
- Extend_E  in  XLEN  sign-extended immediate
- Alu_op_E  in  3  ALU control
- Alu_src_E  in  1  0 = operand B is forwarded rs2; 1 = operand B is Extend_E
- DM_Write_E  in  1  data-memory write enable for this instruction
- Result_E  in  1  result-source select, passed through to WB
- RF_WE_E  in  1  register-file write enable for this instruction
- RD_E  in  5  destination register
- Rs1_E  in  5  source register 1 address
- Rs2_E  in  5  source register 2 address
- Result_W  in  XLEN  final writeback value (same value fed to the RF write port)
- RD_W  in  5  writeback destination register
- RF_WE_W  in  1  writeback write enable
- ALU_Result_M  out  XLEN  registered ALU result
- WD_M  out  XLEN  registered store data (forwarded rs2)
- RD_M  out  5  registered destination register
- RF_WE_M  out  1  registered RF write enable
- DM_Write_M  out  1  registered DM write enable
- Result_M  out  1  registered result-source select
- Zero_M  out  1  registered ALU-result-equals-zero flag

Behaviour:
- Reset: when rst = 0, all EX/MEM registers clear asynchronously. All outputs are 0 while reset is held.
  - Reset mid-stream discards the in-flight instruction.
  - The first capture occurs on the first rising edge after rst rises.
- Latency: one cycle. Inputs valid in cycle N appear on the *_M outputs after the edge ending cycle N.
- Forwarding, operand A (combinational; same rule for operand B using Rs2_E):
  - MEM match: if RF_WE_M = 1, RD_M ≠ 0 and RD_M = Rs1_E, select ALU_Result_M.
  - Else WB match: if RF_WE_W = 1, RD_W ≠ 0 and RD_W = Rs1_E, select Result_W.
  - Else select RD1_E.
  - MEM has priority over WB when both match.
  - Source register 0 is never forwarded; the ID/EX value is used.
- SrcB = Alu_src_E ? Extend_E : forwarded rs2.
- WD_M always captures the forwarded rs2, regardless of Alu_src_E.
- ALU encoding (Alu_op_E):
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
  - 101 SLT: signed compare; result is 1 or 0, zero-extended
  - 110 SLL, 111 SRL: shift amount is SrcB[4:0]; SRL is logical
- Arithmetic wraps modulo 2^XLEN. No overflow or carry output.
- Zero_M is registered (ALU result == 0).
- Control bits RF_WE_E, DM_Write_E, Result_E and RD_E pass unmodified into the EX/MEM register.
- Load-use hazards: Result_M = 1 marks a load. Detecting a load-use dependency and stalling are the hazard unit's responsibility. This block forwards ALU_Result_M unconditionally on a MEM match.
- This block has no stall or flush inputs. The EX/MEM register updates on every clock edge.

Test Plan:
- Reset: hold rst = 0 with nonzero inputs and toggle clk → all outputs read 0. Release rst, apply ADD 5 + 7 (Alu_op_E = 000, Alu_src_E = 0) → ALU_Result_M = 12, Zero_M = 0 after one edge.
- MEM forward: cycle 1 ADD x3 = 10 + 20 (RD_E = 3, RF_WE_E = 1). Cycle 2 SUB with Rs1_E = 3, RD1_E = 0xDEAD, RD2_E = 5 → ALU_Result_M = 25.
- MEM vs WB priority: RD_M = 4 with ALU_Result_M = 100, and RD_W = 4 with Result_W = 200. ADD with Rs1_E = 4, Rs2_E = 4 → ALU_Result_M = 200. Repeat with RF_WE_M = 0 → 400.
- x0 guard: RD_M = 0, RF_WE_M = 1, ALU_Result_M = 9, Rs1_E = 0, RD1_E = 0 → operand A = 0, not 9.
- Immediate and store data: Alu_src_E = 1, Extend_E = 0xFFFFFFFC, RD1_E = 4, ADD → ALU_Result_M = 0, Zero_M = 1. In the same instruction, WD_M equals the forwarded rs2 (WB match, Result_W = 0x55 → WD_M = 0x55).
- ALU ops:
  - SLT: 0xFFFFFFFF vs 1 → 1; 1 vs 0xFFFFFFFF → 0.
  - SLL: 1 by 31 → 0x80000000.
  - SRL: 0x80000000 by 31 → 1.
  - XOR: 0xF0F0 ^ 0xFFFF → 0x0F0F.
  - Assert reset mid-sequence → outputs clear immediately, without waiting for a clock edge.
